// File: rtl/fft_spectrum.sv
// Spectrum capture behind the fft block: one frame per request, |re|+|im| bins
// stored in a dual-port RAM with optional exponential averaging and per-frame peak tracking.
module fft_spectrum #(
   parameter  int RN        = 16,
   parameter  int SIZE      = 256,
   parameter  int AVG_SHIFT = 2,
   localparam int AW        = $clog2(SIZE)
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          enable,
   input  logic          clear,
   output logic          request,
   input  logic          valid,
   input  logic [RN-1:0] fft_data,
   output logic          frame_done,
   output logic [AW-1:0] peak_bin,
   output logic [RN-1:0] peak_mag,
   input  logic [AW-1:0] rd_addr,
   output logic [RN-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic          flush_cnt;
   logic          accept, start, done;

   logic          first, frame_first, clr_seen;
   logic [AW-1:0] run_bin;
   logic [RN-1:0] run_mag;

   logic          s0_valid, s0_first;
   logic [AW-1:0] s0_addr;
   logic [RN-1:0] s0_in, old_q;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [RN-1:0] wr_data, avg_val;
   logic          unused_msb;
   logic signed [RN:0] diff, step, sum;

   logic [RN-1:0] ram [SIZE];

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = CAPTURE;
               start     = 1'b1;
            end
         end
         CAPTURE: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (valid) begin
               accept = 1'b1;
               if (&cnt) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (flush_cnt) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A clear seen while a frame is in flight must survive that frame's frame_done.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= IDLE;
         request     <= 1'b0;
         frame_done  <= 1'b0;
         flush_cnt   <= 1'b0;
         cnt         <= '0;
         first       <= 1'b1;
         frame_first <= 1'b1;
         clr_seen    <= 1'b0;
         run_bin     <= '0;
         run_mag     <= '0;
         peak_bin    <= '0;
         peak_mag    <= '0;
      end else begin
         state      <= state_nxt;
         request    <= (state_nxt == CAPTURE);
         frame_done <= done;
         flush_cnt  <= (state == FLUSH) && (state_nxt == FLUSH);
         if (start) begin
            cnt         <= '0;
            run_bin     <= '0;
            run_mag     <= '0;
            frame_first <= first | clear;
            clr_seen    <= 1'b0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (fft_data > run_mag) begin
               run_mag <= fft_data;
               run_bin <= cnt;
            end
         end
         if (clear) first <= 1'b1;
         if (clear && state != IDLE) clr_seen <= 1'b1;
         if (done) begin
            peak_bin <= run_bin;
            peak_mag <= run_mag;
            if (!clr_seen && !clear) first <= 1'b0;
         end
      end
   end

   // Blend in RN+1 signed bits; the result always lands back inside [0, 2^RN-1].
   always_comb begin
      diff = $signed({1'b0, s0_in}) - $signed({1'b0, old_q});
      step = diff >>> AVG_SHIFT;
      sum  = $signed({1'b0, old_q}) + step;
      {unused_msb, avg_val} = sum;
      if (s0_first) avg_val = s0_in;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         s0_valid <= 1'b0;
         s0_first <= 1'b0;
         s0_addr  <= '0;
         s0_in    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rd_data  <= '0;
      end else begin
         s0_valid <= accept;
         if (accept) begin
            s0_addr  <= cnt;
            s0_in    <= fft_data;
            s0_first <= frame_first;
         end
         wr_en   <= s0_valid;
         wr_addr <= s0_addr;
         wr_data <= avg_val;
         rd_data <= ram[rd_addr];
      end
   end

   // NOTE: the bin array is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      if (accept) old_q <= ram[cnt];
   end

endmodule
